// File: rtl/sort_addr_counter.sv
// Up/down address counter with runtime modulo limit, wrap/saturate mode, terminal count and wrap
// pulse. Define SORT_ADDR_COUNTER_CLR_EN to add the synchronous clear port clr.
module sort_addr_counter #(
  parameter int unsigned SIZE = 8,
  localparam int unsigned W = $clog2(SIZE) + 1
) (
  input  logic         clk,
  input  logic         rst,
`ifdef SORT_ADDR_COUNTER_CLR_EN
  input  logic         clr,
`endif
  input  logic         ena,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         dir,
  input  logic         sat,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         tc,
  output logic         wrap
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap_q, wrap_d;
  logic         clr_hit;

`ifdef SORT_ADDR_COUNTER_CLR_EN
  assign clr_hit = clr;
`else
  assign clr_hit = 1'b0;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr_hit) begin
      cnt_d = '0;
    end else if (!ena) begin
      cnt_d = cnt_q;
    end else if (load) begin
      cnt_d = (din > limit) ? limit : din;
    end else if (dir) begin
      if (cnt_q < limit) begin
        cnt_d = cnt_q + 1'b1;
      end else if (sat) begin
        cnt_d = limit;
      end else begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end
    end else begin
      // A count above a freshly lowered limit re-enters the range without wrapping.
      if (cnt_q > limit) begin
        cnt_d = limit;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (!sat) begin
        cnt_d  = limit;
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;
  assign tc   = dir ? (cnt_q >= limit) : (cnt_q == '0);

endmodule
